// File: rtl/data_plane_rx_buffered.sv
// data_plane_rx_buffered: node-ID filtered receive buffer (FIFO or LIFO) with a GPP read port
module data_plane_rx_buffered #(
    parameter int DATA_W    = 16,
    parameter int ID_W      = 16,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 5,
    parameter int LIFO_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_W+DATA_W-1:0]     rx_packet,
    input  logic                       rx_valid,
    input  logic [ID_W-1:0]            node_id,
    input  logic                       rd_req,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       burst_done,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_addr, wr_addr;
    logic [BW-1:0]     burst_cnt;
    logic              match, pop, wr, drop, burst_end;
    assign match     = rx_valid && rx_packet[ID_W+DATA_W-1:DATA_W] == node_id;
    assign pop       = rd_req && !empty;
    assign wr        = match && (!full || pop);
    assign drop      = match && full && !pop;
    assign burst_end = match && burst_cnt == BW'(BURST_LEN - 1);
    assign full      = level == LW'(DEPTH);
    assign empty     = level == '0;
    // In stack mode wr_ptr is the stack pointer; a concurrent push+pop replaces the top slot
    assign rd_addr   = LIFO_MODE != 0 ? wr_ptr - AW'(1) : rd_ptr;
    assign wr_addr   = (LIFO_MODE != 0 && pop) ? wr_ptr - AW'(1) : wr_ptr;
    always_ff @(posedge clk)
        if (wr) mem[wr_addr] <= rx_packet[DATA_W-1:0];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            burst_cnt  <= '0;
            burst_done <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr && !pop) level <= level + LW'(1);
            else if (pop && !wr) level <= level - LW'(1);
            if (LIFO_MODE != 0) begin
                if (wr && !pop) wr_ptr <= wr_ptr + AW'(1);
                else if (pop && !wr) wr_ptr <= wr_ptr - AW'(1);
            end else begin
                if (wr) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
            if (match) burst_cnt <= burst_end ? '0 : burst_cnt + BW'(1);
            burst_done <= burst_end;
            overflow   <= drop || (overflow && !clr_err);
            underflow  <= rd_req && empty;
            rd_valid   <= pop;
            if (pop) rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_data_plane_rx_buffered.sv
// tb_data_plane_rx_buffered: FIFO and LIFO instances share stimulus; queue scoreboard checks reads
module tb_data_plane_rx_buffered;
    logic        clk = 0, rst = 0, rx_valid = 0, rd_req = 0, clr_err = 0;
    logic [31:0] rx_packet = '0;
    logic [15:0] node_id = 16'd3;
    logic [15:0] df, dl;
    logic [4:0]  lvl_f, lvl_l;
    logic        vf, vl, full_f, full_l, emp_f, emp_l, bd_f, bd_l, of_f, of_l, uf_f, uf_l;
    logic [15:0] qf[$], ql[$];
    logic [15:0] ef, el;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    data_plane_rx_buffered #(.LIFO_MODE(0)) dut_f (
        .clk(clk), .rst(rst), .rx_packet(rx_packet), .rx_valid(rx_valid), .node_id(node_id),
        .rd_req(rd_req), .clr_err(clr_err), .rd_data(df), .rd_valid(vf), .level(lvl_f),
        .full(full_f), .empty(emp_f), .burst_done(bd_f), .overflow(of_f), .underflow(uf_f));
    data_plane_rx_buffered #(.LIFO_MODE(1)) dut_l (
        .clk(clk), .rst(rst), .rx_packet(rx_packet), .rx_valid(rx_valid), .node_id(node_id),
        .rd_req(rd_req), .clr_err(clr_err), .rd_data(dl), .rd_valid(vl), .level(lvl_l),
        .full(full_l), .empty(emp_l), .burst_done(bd_l), .overflow(of_l), .underflow(uf_l));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [15:0] d, input logic [15:0] p);
        rx_valid = v;
        rx_packet = {d, p};
        if (v && d == node_id) begin
            if (qf.size() < 16) qf.push_back(p);
            if (ql.size() < 16) ql.push_back(p);
        end
        cyc();
        rx_valid = 0;
    endtask

    task automatic rd();
        rd_req = 1;
        cyc();
        rd_req = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) cyc();
        checks++;
        if ({lvl_f, emp_f, full_f, vf, bd_f, of_f, uf_f} !== {5'd0, 6'b100000}) begin
            fails++; $display("FAIL reset_fifo: got %b want %b", {lvl_f, emp_f, full_f, vf, bd_f, of_f, uf_f}, {5'd0, 6'b100000});
        end
        checks++;
        if ({lvl_l, emp_l, full_l, vl, bd_l, of_l, uf_l} !== {5'd0, 6'b100000}) begin
            fails++; $display("FAIL reset_lifo: got %b want %b", {lvl_l, emp_l, full_l, vl, bd_l, of_l, uf_l}, {5'd0, 6'b100000});
        end
        rst = 1;
        cyc();
    endtask

    task automatic test_burst_order();
        for (int i = 0; i < 5; i++) begin
            send(1, 16'd3, 16'h0A + 16'(i));
            checks++;
            if (bd_f !== (i == 4) || bd_l !== (i == 4)) begin
                fails++; $display("FAIL burst_done_%0d: got %b/%b want %b", i, bd_f, bd_l, i == 4);
            end
        end
        cyc();
        checks++;
        if (bd_f !== 0 || bd_l !== 0) begin
            fails++; $display("FAIL burst_done_single: got %b/%b want 0", bd_f, bd_l);
        end
        checks++;
        if (lvl_f !== 5 || lvl_l !== 5) begin
            fails++; $display("FAIL level5: got %0d/%0d want 5", lvl_f, lvl_l);
        end
        for (int i = 0; i < 5; i++) begin
            rd();
            ef = qf.pop_front();
            el = ql.pop_back();
            checks++;
            if (vf !== 1 || df !== ef) begin
                fails++; $display("FAIL fifo_read_%0d: got v=%b %h want v=1 %h", i, vf, df, ef);
            end
            checks++;
            if (vl !== 1 || dl !== el) begin
                fails++; $display("FAIL lifo_read_%0d: got v=%b %h want v=1 %h", i, vl, dl, el);
            end
        end
        rd();
        checks++;
        if (uf_f !== 1 || uf_l !== 1 || vf !== 0 || vl !== 0) begin
            fails++; $display("FAIL underflow: got uf=%b/%b v=%b/%b want uf=1 v=0", uf_f, uf_l, vf, vl);
        end
        checks++;
        if (df !== 16'h0E || dl !== 16'h0A) begin
            fails++; $display("FAIL rd_data_hold: got %h/%h want 000e/000a", df, dl);
        end
        cyc();
        checks++;
        if (uf_f !== 0 || uf_l !== 0) begin
            fails++; $display("FAIL underflow_pulse: got %b/%b want 0", uf_f, uf_l);
        end
    endtask

    task automatic test_filter();
        logic [15:0] dst [8] = '{16'd7, 16'd3, 16'd3, 16'd3, 16'd7, 16'd3, 16'd3, 16'd3};
        logic        val [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int m = 0;
        logic exp_bd;
        for (int i = 0; i < 8; i++) begin
            exp_bd = 0;
            if (val[i] && dst[i] == 16'd3) begin
                m++;
                exp_bd = (m % 5 == 0);
            end
            send(val[i], dst[i], 16'h50 + 16'(i));
            checks++;
            if (bd_f !== exp_bd || bd_l !== exp_bd) begin
                fails++; $display("FAIL filter_bd_%0d: got %b/%b want %b", i, bd_f, bd_l, exp_bd);
            end
        end
        checks++;
        if (lvl_f !== 5 || lvl_l !== 5) begin
            fails++; $display("FAIL filter_level: got %0d/%0d want 5", lvl_f, lvl_l);
        end
        for (int i = 0; i < 5; i++) begin
            rd();
            ef = qf.pop_front();
            el = ql.pop_back();
            checks++;
            if (vf !== 1 || df !== ef || vl !== 1 || dl !== el) begin
                fails++; $display("FAIL filter_read_%0d: got %h/%h want %h/%h", i, df, dl, ef, el);
            end
        end
    endtask

    task automatic test_overflow_and_full_rw();
        for (int i = 0; i < 16; i++) send(1, 16'd3, 16'h100 + 16'(i));
        checks++;
        if (full_f !== 1 || full_l !== 1 || lvl_f !== 16 || lvl_l !== 16 || of_f !== 0) begin
            fails++; $display("FAIL fill: got full=%b/%b lvl=%0d/%0d want full=1 lvl=16", full_f, full_l, lvl_f, lvl_l);
        end
        send(1, 16'd3, 16'h1FF);
        checks++;
        if (of_f !== 1 || of_l !== 1 || lvl_f !== 16 || lvl_l !== 16) begin
            fails++; $display("FAIL overflow: got of=%b/%b lvl=%0d/%0d want of=1 lvl=16", of_f, of_l, lvl_f, lvl_l);
        end
        clr_err = 1;
        cyc();
        clr_err = 0;
        checks++;
        if (of_f !== 0 || of_l !== 0) begin
            fails++; $display("FAIL clr_err: got %b/%b want 0", of_f, of_l);
        end
        rx_valid = 1;
        rx_packet = {16'd3, 16'h0077};
        rd_req = 1;
        ef = qf.pop_front();
        el = ql.pop_back();
        qf.push_back(16'h0077);
        ql.push_back(16'h0077);
        cyc();
        rx_valid = 0;
        rd_req = 0;
        checks++;
        if (vf !== 1 || df !== ef || vl !== 1 || dl !== el) begin
            fails++; $display("FAIL full_rw_read: got %h/%h want %h/%h", df, dl, ef, el);
        end
        checks++;
        if (lvl_f !== 16 || lvl_l !== 16 || of_f !== 0 || of_l !== 0) begin
            fails++; $display("FAIL full_rw_state: got lvl=%0d/%0d of=%b/%b want 16 of=0", lvl_f, lvl_l, of_f, of_l);
        end
        for (int i = 0; i < 16; i++) begin
            rd();
            ef = qf.pop_front();
            el = ql.pop_back();
            checks++;
            if (vf !== 1 || df !== ef || vl !== 1 || dl !== el) begin
                fails++; $display("FAIL drain_%0d: got %h/%h want %h/%h", i, df, dl, ef, el);
            end
        end
        checks++;
        if (emp_f !== 1 || emp_l !== 1) begin
            fails++; $display("FAIL drained_empty: got %b/%b want 1", emp_f, emp_l);
        end
    endtask

    task automatic test_async_reset();
        int pf = 0, pl = 0;
        for (int i = 0; i < 3; i++) send(1, 16'd3, 16'h200 + 16'(i));
        #2 rst = 0;
        #1;
        checks++;
        if (lvl_f !== 0 || lvl_l !== 0 || emp_f !== 1 || emp_l !== 1 || vf !== 0 || df !== 0) begin
            fails++; $display("FAIL async_reset: got lvl=%0d/%0d empty=%b/%b want 0 empty=1", lvl_f, lvl_l, emp_f, emp_l);
        end
        qf.delete();
        ql.delete();
        #2 rst = 1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            if (i < 5) send(1, 16'd3, 16'h300 + 16'(i));
            else cyc();
            pf += int'(bd_f);
            pl += int'(bd_l);
        end
        checks++;
        if (pf != 1 || pl != 1) begin
            fails++; $display("FAIL reset_burst_count: got %0d/%0d pulses want 1", pf, pl);
        end
        checks++;
        if (lvl_f !== 5 || lvl_l !== 5) begin
            fails++; $display("FAIL reset_refill_level: got %0d/%0d want 5", lvl_f, lvl_l);
        end
    endtask

    initial begin
        test_reset();
        test_burst_order();
        test_filter();
        test_overflow_and_full_rw();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
